// File: rtl/instr_encoder_fifo.sv
// instr_encoder_fifo: packs a format code, register fields and a 64-bit signed
// immediate into a 32-bit LEGv8 word (LDUR/STUR/CBZ). Words whose immediate
// cannot be recovered by sign extension, and illegal formats, are dropped and
// flagged. Accepted words pass through one register stage (S1) and then queue
// in a DEPTH-entry FIFO for the consumer.
module instr_encoder_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_fmt,
   input  logic [63:0]             in_imm,
   input  logic [4:0]              in_rn,
   input  logic [4:0]              in_rt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_word,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    err_range,
   output logic                    err_fmt,
   input  logic                    err_clear
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   // D-type immediates are 9-bit signed: everything above bit 8 must be a copy of bit 8
   function automatic logic d_imm_fits(input logic [63:0] imm);
      return (&imm[63:8]) | ~(|imm[63:8]);
   endfunction

   // CB-type immediates are 19-bit signed
   function automatic logic cb_imm_fits(input logic [63:0] imm);
      return (&imm[63:18]) | ~(|imm[63:18]);
   endfunction

   function automatic logic [31:0] encode_word(input logic [1:0]  fmt,
                                               input logic [63:0] imm,
                                               input logic [4:0]  rn,
                                               input logic [4:0]  rt);
      logic [31:0] w;
      case (fmt)
         2'd0:    w = {11'b11111000010, imm[8:0], 2'b00, rn, rt};
         2'd1:    w = {11'b11111000000, imm[8:0], 2'b00, rn, rt};
         default: w = {8'b10110100, imm[18:0], rt};
      endcase
      return w;
   endfunction

   logic              s1_valid_q, s1_valid_d;
   logic [31:0]       s1_word_q, s1_word_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              err_range_q, err_range_d;
   logic              err_fmt_q, err_fmt_d;
   logic [31:0]       mem_q [DEPTH];

   logic              accept;
   logic              fmt_bad;
   logic              imm_ok;
   logic              load;
   logic              push;
   logic              pop;
   logic [LW-1:0]     occupancy;

   // S1 counts against capacity so that a word in S1 always has a FIFO slot waiting
   assign occupancy = level_q + LW'(s1_valid_q);
   assign in_ready  = reset & (occupancy < LW'(DEPTH));
   assign out_valid = reset & (level_q != '0);
   assign pop       = out_valid & out_ready;
   assign out_word  = out_valid ? mem_q[rd_ptr_q] : 32'd0;
   assign level     = reset ? level_q : '0;
   assign err_range = reset & err_range_q;
   assign err_fmt   = reset & err_fmt_q;

   // Next-state: accept/drop decision, S1 hand-off, FIFO pointers and sticky errors
   always_comb begin
      accept  = in_valid & in_ready;
      fmt_bad = (in_fmt == 2'd3);
      imm_ok  = (in_fmt == 2'd2) ? cb_imm_fits(in_imm) : d_imm_fits(in_imm);
      load    = accept & ~fmt_bad & imm_ok;
      push    = reset & s1_valid_q & ((level_q != LW'(DEPTH)) | pop);

      s1_valid_d = load | (s1_valid_q & ~push);
      s1_word_d  = load ? encode_word(in_fmt, in_imm, in_rn, in_rt) : s1_word_q;

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // a new error on the clearing edge wins over the clear
      err_range_d = (err_clear ? 1'b0 : err_range_q) | (accept & ~fmt_bad & ~imm_ok);
      err_fmt_d   = (err_clear ? 1'b0 : err_fmt_q) | (accept & fmt_bad);
   end

   // Control state: synchronous active-low reset discards everything buffered
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         err_range_q <= 1'b0;
         err_fmt_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         err_range_q <= err_range_d;
         err_fmt_q   <= err_fmt_d;
      end
   end

   // Data storage: qualified by the valid/occupancy state, so no reset needed
   always_ff @(posedge clk) begin
      s1_word_q <= s1_word_d;
      if (push) begin
         mem_q[wr_ptr_q] <= s1_word_q;
      end
   end

endmodule

// File: tb/tb_instr_encoder_fifo.sv
// tb_instr_encoder_fifo: directed and scoreboard checks for instr_encoder_fifo.
module tb_instr_encoder_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_fmt;
   logic [63:0] in_imm;
   logic [4:0]  in_rn;
   logic [4:0]  in_rt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [2:0]  level;
   logic        err_range;
   logic        err_fmt;
   logic        err_clear;

   int n_checks = 0;
   int n_fail   = 0;

   instr_encoder_fifo #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_imm(in_imm), .in_rn(in_rn), .in_rt(in_rt),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .level(level), .err_range(err_range), .err_fmt(err_fmt), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request and holds it until it is accepted (bounded).
   task automatic drive_req(input logic [1:0] f, input longint imm,
                            input logic [4:0] rn, input logic [4:0] rt, output bit ok);
      in_fmt = f; in_imm = imm; in_rn = rn; in_rt = rt; in_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         tick();
      end
      in_valid = 1'b0;
   endtask

   // Reference encoding from the instruction formats.
   function automatic logic [31:0] model_enc(input logic [1:0] f, input longint imm,
                                             input logic [4:0] rn, input logic [4:0] rt);
      logic [63:0] u;
      u = imm;
      if (f == 2'd0) return {11'b11111000010, u[8:0], 2'b00, rn, rt};
      if (f == 2'd1) return {11'b11111000000, u[8:0], 2'b00, rn, rt};
      return {8'b10110100, u[18:0], rt};
   endfunction

   // Sign extender that the emitted words must round-trip through.
   function automatic longint signext(input logic [31:0] w);
      logic [63:0] r;
      if (w[31:24] == 8'hB4) r = {{45{w[23]}}, w[23:5]};
      else                   r = {{55{w[20]}}, w[20:12]};
      return longint'(r);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_word !== 32'd0) begin n_fail++; $display("FAIL reset_out_word got %h want 0", out_word); end
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
      n_checks++; if ({err_range, err_fmt} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", {err_range, err_fmt}); end
      reset = 1'b1;
      tick();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_latency();
      bit ok;
      drive_req(2'd0, 64'sd1, 5'd0, 5'd0, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL lat_accept got timeout want accept"); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got out_valid=%b want 0 one edge after accept", out_valid); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1 two edges after accept", out_valid); end
      n_checks++; if (out_word !== 32'hF8401000) begin n_fail++; $display("FAIL lat_word got %h want F8401000", out_word); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pop got level=%0d valid=%b want 0/0", level, out_valid); end
   endtask

   task automatic test_encode();
      logic [1:0]  tf [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2};
      longint      ti [7] = '{-256, 9, 1, -1, 255, -262144, 262143};
      logic [4:0]  tn [7] = '{5'd0, 5'd2, 5'd31, 5'd7, 5'd31, 5'd0, 5'd0};
      logic [4:0]  tt [7] = '{5'd0, 5'd3, 5'd0, 5'd5, 5'd31, 5'd1, 5'd0};
      logic [31:0] te [7] = '{32'hF8500000, 32'hF8009043, 32'hB4000020, 32'hB4FFFFE5,
                              32'hF84FF3FF, 32'hB4800001, 32'hB47FFFE0};
      bit ok;
      for (int i = 0; i < 7; i++) begin
         drive_req(tf[i], ti[i], tn[i], tt[i], ok);
         tick();
         n_checks++;
         if (!ok || out_valid !== 1'b1 || out_word !== te[i]) begin
            n_fail++;
            $display("FAIL encode_%0d got valid=%b word=%h want 1/%h", i, out_valid, out_word, te[i]);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_errors();
      bit ok;
      drive_req(2'd0, 64'sd256, 5'd1, 5'd1, ok);
      n_checks++; if (!ok || err_range !== 1'b1 || err_fmt !== 1'b0) begin n_fail++; $display("FAIL err_ldur256 got ok=%b range=%b fmt=%b want 1/1/0", ok, err_range, err_fmt); end
      tick(); tick();
      n_checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL err_dropped got valid=%b level=%0d want 0/0", out_valid, level); end
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      n_checks++; if (err_range !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", err_range); end
      drive_req(2'd1, -64'sd257, 5'd0, 5'd0, ok);
      n_checks++; if (err_range !== 1'b1) begin n_fail++; $display("FAIL err_stur_m257 got %b want 1", err_range); end
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      drive_req(2'd2, 64'sd262144, 5'd0, 5'd0, ok);
      tick(); tick();
      n_checks++; if (err_range !== 1'b1 || level !== 3'd0) begin n_fail++; $display("FAIL err_cbz_range got range=%b level=%0d want 1/0", err_range, level); end
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      drive_req(2'd3, 64'sd0, 5'd0, 5'd0, ok);
      tick(); tick();
      n_checks++; if (err_fmt !== 1'b1 || err_range !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL err_fmt got fmt=%b range=%b level=%0d want 1/0/0", err_fmt, err_range, level); end
      err_clear = 1'b1;
      drive_req(2'd3, 64'sd0, 5'd0, 5'd0, ok);
      err_clear = 1'b0;
      n_checks++; if (err_fmt !== 1'b1) begin n_fail++; $display("FAIL err_clear_vs_new got %b want 1", err_fmt); end
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      n_checks++; if ({err_range, err_fmt} !== 2'b00) begin n_fail++; $display("FAIL err_final_clear got %b want 00", {err_range, err_fmt}); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_w [6] = '{32'hF8400000, 32'hF8401021, 32'hF8402042,
                                 32'hF8403063, 32'hF8404084, 32'hF84050A5};
      int acc = 0;
      int got = 0;
      bit hs;
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         in_valid = (acc < 6);
         in_fmt = 2'd0; in_imm = 64'(acc); in_rn = 5'(acc); in_rt = 5'(acc);
         hs = in_valid & in_ready;
         tick();
         if (hs) acc++;
      end
      n_checks++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted got %0d want 4", acc); end
      n_checks++; if (level !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got level=%0d in_ready=%b want 4/0", level, in_ready); end
      n_checks++; if (out_word !== exp_w[0]) begin n_fail++; $display("FAIL bp_head_stable got %h want %h", out_word, exp_w[0]); end
      out_ready = 1'b1;
      for (int c = 0; c < 40 && got < 6; c++) begin
         in_valid = (acc < 6);
         in_fmt = 2'd0; in_imm = 64'(acc); in_rn = 5'(acc); in_rt = 5'(acc);
         hs = in_valid & in_ready;
         if (out_valid) begin
            n_checks++;
            if (out_word !== exp_w[got]) begin n_fail++; $display("FAIL bp_order_%0d got %h want %h", got, out_word, exp_w[got]); end
            got++;
         end
         tick();
         if (hs) acc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_checks++; if (got != 6) begin n_fail++; $display("FAIL bp_drained got %0d words want 6", got); end
   endtask

   task automatic test_random();
      logic [31:0] sb_w [$];
      longint      sb_i [$];
      int kind, v;
      longint imm;
      logic [1:0] f;
      logic [4:0] rn, rt;
      bit legal;
      for (int c = 0; c < 300; c++) begin
         kind = $urandom_range(0, 9);
         rn = 5'($urandom_range(0, 31));
         rt = 5'($urandom_range(0, 31));
         legal = 1'b1;
         if (kind == 0) begin
            f = 2'd3; imm = 0; legal = 1'b0;
         end else if (kind == 1) begin
            f = 2'($urandom_range(0, 1)); v = $urandom_range(256, 5000); imm = longint'(v); legal = 1'b0;
         end else if (kind < 6) begin
            f = 2'($urandom_range(0, 1)); v = $urandom_range(0, 511) - 256; imm = longint'(v);
         end else begin
            f = 2'd2; v = $urandom_range(0, 524287) - 262144; imm = longint'(v);
         end
         in_valid = ($urandom_range(0, 9) < 7);
         in_fmt = f; in_imm = imm; in_rn = rn; in_rt = rt;
         out_ready = ($urandom_range(0, 9) < 7);
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb_w.size() == 0) begin
               n_fail++; $display("FAIL rnd_extra got %h want no word", out_word);
            end else begin
               if (out_word !== sb_w[0]) begin n_fail++; $display("FAIL rnd_word got %h want %h", out_word, sb_w[0]); end
               n_checks++;
               if (signext(out_word) != sb_i[0]) begin n_fail++; $display("FAIL rnd_signext got %0d want %0d", signext(out_word), sb_i[0]); end
               void'(sb_w.pop_front());
               void'(sb_i.pop_front());
            end
         end
         if (in_valid && in_ready && legal) begin
            sb_w.push_back(model_enc(f, imm, rn, rt));
            sb_i.push_back(imm);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && sb_w.size() > 0; c++) begin
         if (out_valid) begin
            n_checks++;
            if (out_word !== sb_w[0]) begin n_fail++; $display("FAIL rnd_drain got %h want %h", out_word, sb_w[0]); end
            void'(sb_w.pop_front());
            void'(sb_i.pop_front());
         end
         tick();
      end
      out_ready = 1'b0;
      n_checks++; if (sb_w.size() != 0 || level !== 3'd0) begin n_fail++; $display("FAIL rnd_empty got left=%0d level=%0d want 0/0", sb_w.size(), level); end
      err_clear = 1'b1; tick(); err_clear = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      out_ready = 1'b0;
      drive_req(2'd3, 64'sd0, 5'd0, 5'd0, ok);
      for (int i = 0; i < 3; i++) drive_req(2'd1, longint'(i), 5'd4, 5'd4, ok);
      tick(); tick();
      n_checks++; if (level !== 3'd3 || err_fmt !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup got level=%0d fmt=%b want 3/1", level, err_fmt); end
      reset = 1'b0;
      tick();
      n_checks++; if (out_valid !== 1'b0 || level !== 3'd0 || {err_range, err_fmt} !== 2'b00 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid got valid=%b level=%0d err=%b rdy=%b want 0/0/00/0", out_valid, level, {err_range, err_fmt}, in_ready);
      end
      reset = 1'b1;
      tick();
      n_checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after got level=%0d valid=%b want 0/0", level, out_valid); end
      drive_req(2'd0, 64'sd5, 5'd1, 5'd2, ok);
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_word !== 32'hF8405022 || level !== 3'd1) begin
         n_fail++; $display("FAIL rst_first_word got valid=%b word=%h level=%0d want 1/F8405022/1", out_valid, out_word, level);
      end
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_fmt = 2'd0; in_imm = 64'd0;
      in_rn = 5'd0; in_rt = 5'd0; out_ready = 1'b0; err_clear = 1'b0;
      #1;
      test_reset();
      test_latency();
      test_encode();
      test_errors();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
